// File: rtl/mxalu11u_arb.sv
// mxalu11u_arb: round-robin front end that lets two requesters share one 8-bit ALU,
// with a one-deep registered response slot. Build option MXALU11U_ARB_ZERO_EN adds rsp_zero.
module mxalu11u_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_opcode,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_opcode,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_f,
   output logic       rsp_cout,
   output logic       rsp_eq,
   output logic       rsp_x,
   output logic       rsp_y,
   output logic [3:0] alu_opcode,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_cs_n,
   input  logic [7:0] alu_f,
   input  logic       alu_x,
   input  logic       alu_y,
   input  logic       alu_a_b,
   input  logic       alu_cn4_n,
   input  logic       alu_cn8_n
`ifdef MXALU11U_ARB_ZERO_EN
   ,
   output logic       rsp_zero
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state_r;
   logic       last_r;
   logic       id_r;
   logic [3:0] alu_opcode_r;
   logic [7:0] alu_a_r;
   logic [7:0] alu_b_r;
   logic       alu_cs_n_r;
   logic       rsp_valid_r;
   logic [7:0] rsp_f_r;
   logic       rsp_cout_r;
   logic       rsp_eq_r;
   logic       rsp_x_r;
   logic       rsp_y_r;

   logic       grant1_s;
   logic       req0_ready_s;
   logic       req1_ready_s;
   logic       unused_s;

   // The low-nibble carry is visible on the ALU bus but plays no part in the response.
   assign unused_s = alu_cn4_n;

   // Grant selection: a lone valid requester wins, a tie goes to the one not served last.
   always_comb begin
      grant1_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant1_s = ~last_r;
      end else if (req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant1_s = 1'b0;
      end
   end

   // Ready pulses only in IDLE, only for the granted valid requester, never during reset.
   always_comb begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
      if (rst_n && (state_r == IDLE)) begin
         req0_ready_s = req0_valid && !grant1_s;
         req1_ready_s = req1_valid && grant1_s;
      end else begin
         req0_ready_s = 1'b0;
         req1_ready_s = 1'b0;
      end
   end

   // Control FSM with the ALU drive registers and the response slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         last_r       <= 1'b1;
         id_r         <= 1'b0;
         alu_opcode_r <= 4'h0;
         alu_a_r      <= 8'h00;
         alu_b_r      <= 8'h00;
         alu_cs_n_r   <= 1'b1;
         rsp_valid_r  <= 1'b0;
         rsp_f_r      <= 8'h00;
         rsp_cout_r   <= 1'b0;
         rsp_eq_r     <= 1'b0;
         rsp_x_r      <= 1'b0;
         rsp_y_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req0_ready_s || req1_ready_s) begin
                  id_r         <= req1_ready_s;
                  last_r       <= req1_ready_s;
                  alu_opcode_r <= req1_ready_s ? req1_opcode : req0_opcode;
                  alu_a_r      <= req1_ready_s ? req1_a : req0_a;
                  alu_b_r      <= req1_ready_s ? req1_b : req0_b;
                  alu_cs_n_r   <= 1'b0;
                  state_r      <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_f_r     <= alu_f;
               rsp_cout_r  <= ~alu_cn8_n;
               rsp_eq_r    <= alu_a_b;
               rsp_x_r     <= alu_x;
               rsp_y_r     <= alu_y;
               alu_cs_n_r  <= 1'b1;
               rsp_valid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               alu_cs_n_r  <= 1'b1;
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

`ifdef MXALU11U_ARB_ZERO_EN
   logic rsp_zero_r;

   // Zero flag is taken from the same ALU sample as rsp_f and held with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_zero_r <= 1'b0;
      end else if (state_r == ISSUE) begin
         rsp_zero_r <= (alu_f == 8'h00);
      end
   end

   assign rsp_zero = rsp_zero_r;
`endif

   assign req0_ready = req0_ready_s;
   assign req1_ready = req1_ready_s;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = id_r;
   assign rsp_f      = rsp_f_r;
   assign rsp_cout   = rsp_cout_r;
   assign rsp_eq     = rsp_eq_r;
   assign rsp_x      = rsp_x_r;
   assign rsp_y      = rsp_y_r;
   assign alu_opcode = alu_opcode_r;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign alu_cs_n   = alu_cs_n_r;

endmodule
